karatsuba_seq: RTL and testbench

Multi-cycle unsigned N×N multiplier controller that time-shares one combinational karatsuba #(N/2) instance across the three Karatsuba partial products (P3=A_h*B_h, P2=A_l*B_l, P1=|A_l-A_h|*|B_h-B_l|). It then recombines them into the 2N-bit product. It sits between a valid/ready producer and consumer and trades latency for a third of the multiplier area of the fully parallel karatsuba #(N).

---
 rtl/karatsuba_pkg.sv | 20 ++
 rtl/karatsuba.sv | 34 +++
 rtl/karatsuba_seq.sv | 145 ++++++++++++++
 tb/tb_karatsuba_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared types and width helpers for the sequential Karatsuba multiplier.
package karatsuba_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_HH = 3'd1,
        MUL_LL = 3'd2,
        MUL_MM = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int half_w(input int n);
        return n / 2;
    endfunction

    function automatic int mid_w(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/karatsuba.sv
// Combinational unsigned NxN multiplier, one Karatsuba split over plain half-width products.
module karatsuba #(
    parameter int N = 8
) (
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] C
);

    localparam int H = N / 2;

    generate
        if (N < 4) begin : g_leaf
            assign C = {{N{1'b0}}, A} * {{N{1'b0}}, B};
        end else begin : g_split
            logic [H:0]     sa;
            logic [H:0]     sb;
            logic [2*H-1:0] p_hh;
            logic [2*H-1:0] p_ll;
            logic [2*H+1:0] p_ss;
            logic [2*H+1:0] mid;

            assign sa   = {1'b0, A[H-1:0]} + {1'b0, A[N-1:H]};
            assign sb   = {1'b0, B[H-1:0]} + {1'b0, B[N-1:H]};
            assign p_hh = {{H{1'b0}}, A[N-1:H]} * {{H{1'b0}}, B[N-1:H]};
            assign p_ll = {{H{1'b0}}, A[H-1:0]} * {{H{1'b0}}, B[H-1:0]};
            assign p_ss = {{(H+1){1'b0}}, sa} * {{(H+1){1'b0}}, sb};
            // Cross term ah*bl + al*bh is never negative, so unsigned subtraction is exact.
            assign mid  = p_ss - {2'b00, p_hh} - {2'b00, p_ll};
            assign C    = {p_hh, p_ll} + ({{(N-2){1'b0}}, mid} << H);
        end
    endgenerate

endmodule

// File: rtl/karatsuba_seq.sv
// Multi-cycle NxN multiplier sharing one karatsuba #(N/2) across P3, P2, P1.
// Optional KARATSUBA_SEQ_SKIP_EN skips MUL_MM when either middle difference is zero.
module karatsuba_seq
    import karatsuba_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] C,
    output logic           busy
);

    localparam int HALF  = half_w(N);
    localparam int MID_W = mid_w(N);
    localparam int CW    = 2 * N;

    state_t state, state_nxt;

    logic [HALF-1:0] a_h, a_l, b_h, b_l;
    logic [HALF-1:0] abs_a_m, abs_b_m;
    logic            sign;
    logic [N-1:0]    p3, p2;
    logic [HALF-1:0] mul_a, mul_b;
    logic [N-1:0]    mul_p;
    logic signed [HALF:0] a_m, b_m;
    logic            accept;
`ifdef KARATSUBA_SEQ_SKIP_EN
    logic            zero_m;
`endif

    function automatic logic [HALF-1:0] abs_diff(input logic signed [HALF:0] v);
        logic signed [HALF:0] neg;
        neg = -v;
        return v[HALF] ? neg[HALF-1:0] : v[HALF-1:0];
    endfunction

    // mid = P3 + P2 -/+ P1 stays in [0, 2^(N+1)), so the widened add never overflows.
    function automatic logic [CW-1:0] recombine(input logic [N-1:0] hh,
                                                input logic [N-1:0] ll,
                                                input logic [N-1:0] mm,
                                                input logic         neg);
        logic signed [MID_W-1:0] mid;
        logic [CW-1:0]           mid_ext;
        mid = $signed({2'b00, hh}) + $signed({2'b00, ll});
        mid = neg ? (mid - $signed({2'b00, mm})) : (mid + $signed({2'b00, mm}));
        mid_ext = CW'($unsigned(mid));
        return {hh, {N{1'b0}}} + (mid_ext << HALF) + CW'(ll);
    endfunction

    assign a_m    = $signed({1'b0, A[HALF-1:0]}) - $signed({1'b0, A[N-1:HALF]});
    assign b_m    = $signed({1'b0, B[N-1:HALF]}) - $signed({1'b0, B[HALF-1:0]});
    assign accept = in_valid && in_ready;

    karatsuba #(.N(HALF)) u_mul (
        .A (mul_a),
        .B (mul_b),
        .C (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_valid) state_nxt = MUL_HH;
            MUL_HH: state_nxt = MUL_LL;
`ifdef KARATSUBA_SEQ_SKIP_EN
            MUL_LL: state_nxt = zero_m ? DONE : MUL_MM;
`else
            MUL_LL: state_nxt = MUL_MM;
`endif
            MUL_MM: state_nxt = DONE;
            DONE:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplier inputs park at zero outside the three product states.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            MUL_HH: begin mul_a = a_h;     mul_b = b_h;     end
            MUL_LL: begin mul_a = a_l;     mul_b = b_l;     end
            MUL_MM: begin mul_a = abs_a_m; mul_b = abs_b_m; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_h     <= '0;
            a_l     <= '0;
            b_h     <= '0;
            b_l     <= '0;
            abs_a_m <= '0;
            abs_b_m <= '0;
            sign    <= 1'b0;
            p3      <= '0;
            p2      <= '0;
            C       <= '0;
`ifdef KARATSUBA_SEQ_SKIP_EN
            zero_m  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_h     <= A[N-1:HALF];
                a_l     <= A[HALF-1:0];
                b_h     <= B[N-1:HALF];
                b_l     <= B[HALF-1:0];
                abs_a_m <= abs_diff(a_m);
                abs_b_m <= abs_diff(b_m);
                sign    <= a_m[HALF] ^ b_m[HALF];
`ifdef KARATSUBA_SEQ_SKIP_EN
                zero_m  <= (a_m == '0) || (b_m == '0);
`endif
            end
            case (state)
                MUL_HH: p3 <= mul_p;
                MUL_LL: begin
                    p2 <= mul_p;
`ifdef KARATSUBA_SEQ_SKIP_EN
                    if (zero_m) C <= recombine(p3, mul_p, '0, sign);
`endif
                end
                MUL_MM: C <= recombine(p3, p2, mul_p, sign);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_seq.sv
// Directed-vector bench for karatsuba_seq (N=16), including backpressure and mid-op reset.
module tb_karatsuba_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] C;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef KARATSUBA_SEQ_SKIP_EN
    localparam int SKIP_LAT = 3;
`else
    localparam int SKIP_LAT = 4;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        bit          skip;
        string       name;
    } vec_t;

    vec_t vecs[7];

    karatsuba_seq #(.N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called right after the accepting posedge; counts cycles to out_valid.
    task automatic wait_result(input logic [31:0] exp_c, input int exp_lat, input string nm);
        int lat = 0;
        bit rdy_bad = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (in_ready) rdy_bad = 1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({nm, "_lat"}, lat, exp_lat);
        check({nm, "_c"}, C, exp_c);
        check({nm, "_rdy_lo"}, rdy_bad, 0);
        if (out_ready) begin
            @(negedge clk);
            check({nm, "_idle"}, {busy, in_ready, out_valid}, 3'b010);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_c, input int exp_lat, input string nm);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(exp_c, exp_lat, nm);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 32'h06260060, 1'b0, "mul_1234"};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, "mul_ffff"};
        vecs[2] = '{16'h0000, 16'hABCD, 32'h00000000, 1'b1, "mul_zero"};
        vecs[3] = '{16'h0100, 16'h0100, 32'h00010000, 1'b0, "neg_mid"};
        vecs[4] = '{16'h0505, 16'h1234, 32'h005B5F04, 1'b1, "skip_0505"};
        vecs[5] = '{16'h00FF, 16'h00FF, 32'h0000FE01, 1'b0, "neg_mid_zero"};
        vecs[6] = '{16'hFF00, 16'h00FF, 32'h00FE0100, 1'b0, "pos_mid"};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        #3;
        check("reset_ctrl", {out_valid, busy, in_ready}, 3'b001);
        check("reset_c", C, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].skip ? SKIP_LAT : 4, vecs[i].name);

        // Backpressure: hold the product, ignore a second request until drained.
        out_ready = 1'b0;
        run_op(16'h0003, 16'h0005, 32'h0000000F, 4, "bp");
        A = 16'h0007;
        B = 16'h0009;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {out_valid, in_ready, busy, C}, {3'b101, 32'h0000000F});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle", {busy, in_ready, out_valid}, 3'b010);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(32'd63, 4, "bp_second");

        // Reset while in MUL_LL discards the operation without a clock edge.
        @(negedge clk);
        A = 16'h1234;
        B = 16'h5678;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {out_valid, busy, in_ready}, 3'b001);
        check("midrst_c", C, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0002, 16'h0003, 32'd6, 4, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
